// File: rtl/riscv_pkg.sv
// Shared core types for the write-back path: register/data widths, the
// active-list geometry and the result record carried from a functional
// unit to a register-file write port.
// AL_SIZE normally arrives from the core-wide header. The fallback below
// keeps this slice buildable on its own. The flush-window math assumes
// AL_SIZE is a power of two.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

package riscv_pkg;

   localparam int PREG_W  = 6;
   localparam int DATA_W  = 32;
   localparam int AL_SIZE = `AL_SIZE;
   localparam int AL_W    = $clog2(AL_SIZE);

   typedef struct packed {
      logic              uses_rd;
      logic [PREG_W-1:0] rd;
      logic [DATA_W-1:0] data;
      logic [AL_W-1:0]   al_addr;
   } wb_req_t;

   // Circular membership test for the half-open window [nf, of).
   // Equal bounds give a zero span, so the window is empty.
   function automatic logic in_flush_window(input logic [AL_W-1:0] a,
                                            input logic [AL_W-1:0] nf,
                                            input logic [AL_W-1:0] of);
      logic [AL_W-1:0] off_a;
      logic [AL_W-1:0] span;
      off_a = a - nf;
      span  = of - nf;
      return off_a < span;
   endfunction

   // Saturating add of a 0..3 increment onto a 32-bit event counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic [1:0] n);
      logic [32:0] s;
      s = {1'b0, c} + 33'(n);
      return s[32] ? '1 : s[31:0];
   endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Combinational two-winner rotating picker. The scan starts at ptr_i and
// wraps modulo N_REQ. The first valid requester takes slot 0. The next valid
// requester that does not conflict with slot 0 takes slot 1.
// conflict_i[i*N_REQ+j] is set when requesters i and j must not be granted
// in the same cycle.
module rr_pick2 #(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0]       valid_i,
   input  logic [N_REQ*N_REQ-1:0] conflict_i,
   input  logic [PTR_W-1:0]       ptr_i,
   output logic [N_REQ-1:0]       grant_o,
   output logic                   found0_o,
   output logic [PTR_W-1:0]       idx0_o,
   output logic                   found1_o,
   output logic [PTR_W-1:0]       idx1_o
);

   // Rotating scan that fills slot 0 and then the first compatible slot 1.
   always_comb begin
      int cand;
      grant_o  = '0;
      found0_o = 1'b0;
      idx0_o   = '0;
      found1_o = 1'b0;
      idx1_o   = '0;
      cand     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(ptr_i) + k) % N_REQ;
         if (valid_i[cand]) begin
            if (!found0_o) begin
               found0_o      = 1'b1;
               idx0_o        = PTR_W'(cand);
               grant_o[cand] = 1'b1;
            end else if (!found1_o && !conflict_i[int'(idx0_o)*N_REQ + cand]) begin
               found1_o      = 1'b1;
               idx1_o        = PTR_W'(cand);
               grant_o[cand] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-port arbiter. It shares the two physical-register-file write ports
// among N_REQ result sources, grants up to two of them per cycle in
// round-robin order, and registers the winners onto wb_*.
// Optional feature macro: WB_ARB_PERF_EN adds saturating perf counters.
//
// Handshake: req_ready is a combinational grant. A result transfers on a
// clock edge where req_valid and req_ready are both high. It shows up on
// wb_* exactly one cycle later. A requester keeps valid and its payload
// stable until it sees ready.
module wb_port_arbiter
   import riscv_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ext_stall,
   input  logic                    flush,
   input  logic [AL_W-1:0]         new_front,
   input  logic [AL_W-1:0]         old_front,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_uses_rd,
   input  logic [N_REQ*PREG_W-1:0] req_rd,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ*AL_W-1:0]   req_al_addr,
   output logic [N_REQ-1:0]        req_ready,
   output logic [1:0]              wb_valid,
   output logic [1:0]              wb_uses_rd,
   output logic [2*PREG_W-1:0]     wb_rd,
   output logic [2*DATA_W-1:0]     wb_data,
   output logic [2*AL_W-1:0]       wb_al_addr
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0]             perf_grants,
   output logic [31:0]             perf_conflicts,
   output logic [31:0]             perf_starve
`endif
);

   localparam int PTR_W = $clog2(N_REQ);

   wb_req_t                req [N_REQ];
   logic [N_REQ*N_REQ-1:0] conflict;
   logic [N_REQ-1:0]       grant;
   logic                   found0, found1;
   logic [PTR_W-1:0]       idx0, idx1;
   logic                   go;

   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   wb_req_t                wb_q [2];
   wb_req_t                wb_d [2];
   logic [1:0]             wb_vld_q, wb_vld_d;

   // Unpack the flat request buses and build the pairwise same-rd conflict matrix.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req[i] = '{uses_rd: req_uses_rd[i],
                    rd:      req_rd[i*PREG_W +: PREG_W],
                    data:    req_data[i*DATA_W +: DATA_W],
                    al_addr: req_al_addr[i*AL_W +: AL_W]};
      end
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            conflict[i*N_REQ + j] = (i != j) && req_uses_rd[i] && req_uses_rd[j] &&
                                    (req_rd[i*PREG_W +: PREG_W] == req_rd[j*PREG_W +: PREG_W]);
         end
      end
   end

   rr_pick2 #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
      .valid_i    (req_valid),
      .conflict_i (conflict),
      .ptr_i      (rr_ptr_q),
      .grant_o    (grant),
      .found0_o   (found0),
      .idx0_o     (idx0),
      .found1_o   (found1),
      .idx1_o     (idx1)
   );

   // Flush outranks stall, and either one suppresses every grant.
   assign go        = !flush && !ext_stall;
   assign req_ready = (go && !reset) ? grant : '0;

   // Advance the pointer to one past the last winner. Hold it when nothing is granted.
   always_comb begin
      logic [PTR_W-1:0] last;
      last     = found1 ? idx1 : idx0;
      rr_ptr_d = rr_ptr_q;
      if (go && found0) begin
         rr_ptr_d = (last == PTR_W'(N_REQ - 1)) ? '0 : last + 1'b1;
      end
   end

   // Next write-port contents. A flush holds the registers and only kills
   // in-window entries. A stall drops both valids. Otherwise load the winners.
   always_comb begin
      wb_d     = wb_q;
      wb_vld_d = wb_vld_q;
      if (flush) begin
         for (int p = 0; p < 2; p++) begin
            if (in_flush_window(wb_q[p].al_addr, new_front, old_front)) wb_vld_d[p] = 1'b0;
         end
      end else if (ext_stall) begin
         wb_vld_d = '0;
      end else begin
         wb_vld_d = {found1, found0};
         if (found0) wb_d[0] = req[idx0];
         if (found1) wb_d[1] = req[idx1];
      end
   end

   // Pointer and write-port registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= '0;
         wb_vld_q <= '0;
         for (int p = 0; p < 2; p++) wb_q[p] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         wb_vld_q <= wb_vld_d;
         for (int p = 0; p < 2; p++) wb_q[p] <= wb_d[p];
      end
   end

   assign wb_valid   = wb_vld_q;
   assign wb_uses_rd = {wb_q[1].uses_rd, wb_q[0].uses_rd};
   assign wb_rd      = {wb_q[1].rd, wb_q[0].rd};
   assign wb_data    = {wb_q[1].data, wb_q[0].data};
   assign wb_al_addr = {wb_q[1].al_addr, wb_q[0].al_addr};

`ifdef WB_ARB_PERF_EN
   logic [31:0] grants_q, grants_d;
   logic [31:0] conflicts_q, conflicts_d;
   logic [31:0] starve_q, starve_d;

   // Count handshakes, same-rd deferrals against slot 0, and cycles with more than two requesters.
   always_comb begin
      logic [N_REQ-1:0] row0;
      logic [1:0]       n_grants;
      for (int j = 0; j < N_REQ; j++) row0[j] = conflict[int'(idx0)*N_REQ + j];
      n_grants    = go ? ({1'b0, found0} + {1'b0, found1}) : 2'd0;
      grants_d    = sat_inc(grants_q, n_grants);
      conflicts_d = sat_inc(conflicts_q, {1'b0, go && found0 && (|(req_valid & row0))});
      starve_d    = sat_inc(starve_q, {1'b0, ($countones(req_valid) > 2)});
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grants_q    <= '0;
         conflicts_q <= '0;
         starve_q    <= '0;
      end else begin
         grants_q    <= grants_d;
         conflicts_q <= conflicts_d;
         starve_q    <= starve_d;
      end
   end

   assign perf_grants    = grants_q;
   assign perf_conflicts = conflicts_q;
   assign perf_starve    = starve_q;
`endif

endmodule
